bus_rr_arbiter: RTL and testbench
=================================

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 SHALL have parameter NrHosts, default 3, number of requesting hosts (2..8).
REQ-002 SHALL have parameter DataWidth, default 32, data width.
REQ-003 SHALL have parameter AddressWidth, default 32, address width.
REQ-004 SHALL have parameter MaxOutstanding, default 2, number of accepted requests awaiting a response (1..4).
REQ-005 SHALL have parameter RoundRobin, default 1'b1; 0 selects fixed priority, where the lowest index wins.
REQ-006 clk_i  in  1  the single clock; every flop uses its rising edge.
REQ-007 rst_i  in  1  synchronous, active-high reset.
REQ-008 host_req_i / host_addr_i / host_we_i / host_be_i / host_wdata_i  in  unpacked [NrHosts] of 1/AW/1/4/DW  host request channel.
REQ-009 host_gnt_o / host_rvalid_o / host_err_o  out  [NrHosts] x 1  per-host grant, response valid and response error.
REQ-010 host_rdata_o  out  [NrHosts] x DW  response data.
REQ-011 dev_req_o / dev_addr_o / dev_we_o / dev_be_o / dev_wdata_o  out  1/AW/1/4/DW  device request channel.
REQ-012 dev_gnt_i / dev_rvalid_i / dev_err_i  in  1  device grant, response valid and response error.
REQ-013 dev_rdata_i  in  DW  device response data.
REQ-014 outstanding_o  out  $clog2(MaxOutstanding+1)  current count of accepted requests awaiting a response.
REQ-015 unexp_rsp_o  out  1  sticky flag, set by a response that arrives with no request outstanding.

Function
REQ-016 Winner selection SHALL be combinational among asserted host_req_i, starting at rr_ptr when RoundRobin=1 and at index 0 otherwise.
REQ-017 dev_req_o SHALL be 1 iff any host_req_i is asserted and the tracker is not full; dev_addr_o/we/be/wdata SHALL be the winner's fields, and all zero when dev_req_o=0.
REQ-018 host_gnt_o[w] SHALL equal dev_req_o & dev_gnt_i for winner w only; all other host_gnt_o SHALL be 0.
REQ-019 An accept SHALL be dev_req_o & dev_gnt_i; on an accept, winner w SHALL be pushed into a MaxOutstanding-deep ID FIFO.
REQ-020 On an accept, rr_ptr SHALL become (w+1) mod NrHosts; rr_ptr SHALL be unchanged when there is no accept or when RoundRobin=0.
REQ-021 On dev_rvalid_i with the FIFO non-empty, the head ID h SHALL be popped in the same cycle.
REQ-022 That response SHALL drive host_rvalid_o[h]=1, host_rdata_o[h]=dev_rdata_i and host_err_o[h]=dev_err_i combinationally (zero-cycle latency).
REQ-023 Non-selected hosts SHALL see rvalid=0, rdata=0 and err=0.
REQ-024 Responses SHALL be routed in accept order (in-order device assumed).
REQ-025 On dev_rvalid_i with the FIFO empty, the response SHALL be dropped: no host_rvalid_o is driven and unexp_rsp_o is set until reset.
REQ-026 Full (count==MaxOutstanding) SHALL block dev_req_o even if a pop occurs in the same cycle; no combinational path from dev_rvalid_i to dev_req_o or host_gnt_o.
REQ-027 A simultaneous push and pop when not full SHALL leave the count unchanged and preserve FIFO order.
REQ-028 FIFO pointers SHALL wrap modulo MaxOutstanding.
REQ-029 A requester not granted SHALL keep its request pending; the arbiter holds no request state beyond rr_ptr.

Reset
REQ-030 While rst_i=1 at a clock edge, the following SHALL be cleared on the next edge: rr_ptr=0, FIFO pointers=0, count=0, unexp_rsp_o=0.
REQ-031 During reset, dev_req_o and all host_gnt_o SHALL be forced to 0.
REQ-032 Reset mid-transaction SHALL discard all outstanding IDs; a late dev_rvalid_i after reset SHALL set unexp_rsp_o.

Structure
REQ-033 A shared package bus_arb_pkg SHALL hold the arb_mode_e typedef {ArbFixed, ArbRoundRobin} and the host-ID width function.
REQ-034 The ID FIFO SHALL be one sub-module, bus_arb_id_fifo (params Depth, Width; push/pop/full/empty/count).
REQ-035 The arbiter SHALL contain no latches and no multicycle paths.

Verification
REQ-036 Hosts 0,1,2 all request continuously, dev_gnt_i=1, response 1 cycle later, RoundRobin=1 -> grants follow 0,1,2,0,1,2 and each rdata returns to its own host.
REQ-037 Same stimulus with RoundRobin=0 -> host 0 is granted every cycle; hosts 1 and 2 are never granted.
REQ-038 MaxOutstanding=2, dev_gnt_i=1, dev_rvalid_i held low -> two accepts, outstanding_o=2, then dev_req_o=0. A pop in cycle N re-enables dev_req_o in cycle N+1.
REQ-039 Accept host 2 then host 0; respond with data 0xA5A5A5A5 then 0x5A5A5A5A with err=1 on the second -> host 2 gets 0xA5A5A5A5 (err=0) and host 0 gets 0x5A5A5A5A (err=1).
REQ-040 dev_rvalid_i pulse with nothing outstanding -> no host_rvalid_o, unexp_rsp_o=1 and held until rst_i.
REQ-041 Assert rst_i with 2 outstanding, release, then pulse dev_rvalid_i -> outstanding_o=0, rr_ptr=0, unexp_rsp_o=1.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus round-robin arbiter and its ID FIFO.
package bus_arb_pkg;

    typedef enum logic {
        ArbFixed      = 1'b0,
        ArbRoundRobin = 1'b1
    } arb_mode_e;

    // Host IDs need at least one bit even when there is a single host.
    function automatic int host_id_width(input int nr_hosts);
        return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
    endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// Small in-order FIFO of granted host IDs; the head is visible combinationally
// so a response can be steered in the cycle it arrives.
module bus_arb_id_fifo #(
    parameter int Depth = 2,
    parameter int Width = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [Width-1:0]           wdata_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// N-host to single-device bus arbiter with round-robin or fixed priority,
// bounded outstanding requests and in-order response routing.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int   NrHosts        = 3,
    parameter int   DataWidth      = 32,
    parameter int   AddressWidth   = 32,
    parameter int   MaxOutstanding = 2,
    parameter logic RoundRobin     = 1'b1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                host_req_i   [NrHosts],
    input  logic [AddressWidth-1:0]             host_addr_i  [NrHosts],
    input  logic                                host_we_i    [NrHosts],
    input  logic [3:0]                          host_be_i    [NrHosts],
    input  logic [DataWidth-1:0]                host_wdata_i [NrHosts],
    output logic                                host_gnt_o   [NrHosts],
    output logic                                host_rvalid_o[NrHosts],
    output logic                                host_err_o   [NrHosts],
    output logic [DataWidth-1:0]                host_rdata_o [NrHosts],
    output logic                                dev_req_o,
    output logic [AddressWidth-1:0]             dev_addr_o,
    output logic                                dev_we_o,
    output logic [3:0]                          dev_be_o,
    output logic [DataWidth-1:0]                dev_wdata_o,
    input  logic                                dev_gnt_i,
    input  logic                                dev_rvalid_i,
    input  logic                                dev_err_i,
    input  logic [DataWidth-1:0]                dev_rdata_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                                unexp_rsp_o
);

    localparam int        IdW  = host_id_width(NrHosts);
    localparam arb_mode_e Mode = arb_mode_e'(RoundRobin);

    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic           unexp_q, unexp_d;
    logic [IdW-1:0] start_idx, win_idx, head_id;
    logic [IdW:0]   scan_idx;
    logic           any_req, accept, pop, fifo_full, fifo_empty;

    // Scan from the highest offset down so the lowest offset from start wins.
    always_comb begin
        start_idx = (Mode == ArbRoundRobin) ? rr_ptr_q : '0;
        win_idx   = '0;
        any_req   = 1'b0;
        scan_idx  = '0;
        for (int k = NrHosts - 1; k >= 0; k--) begin
            scan_idx = {1'b0, start_idx} + (IdW+1)'(k);
            if (scan_idx >= (IdW+1)'(NrHosts)) begin
                scan_idx = scan_idx - (IdW+1)'(NrHosts);
            end
            if (host_req_i[scan_idx[IdW-1:0]]) begin
                win_idx = scan_idx[IdW-1:0];
                any_req = 1'b1;
            end
        end
    end

    // Fullness comes from registered count only, keeping dev_rvalid_i off this path.
    assign dev_req_o = any_req & ~fifo_full & ~rst_i;
    assign accept    = dev_req_o & dev_gnt_i;
    assign pop       = dev_rvalid_i & ~fifo_empty;

    always_comb begin
        dev_addr_o  = '0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_wdata_o = '0;
        if (dev_req_o) begin
            dev_addr_o  = host_addr_i[win_idx];
            dev_we_o    = host_we_i[win_idx];
            dev_be_o    = host_be_i[win_idx];
            dev_wdata_o = host_wdata_i[win_idx];
        end
    end

    for (genvar gi = 0; gi < NrHosts; gi++) begin : g_host
        logic rsp_hit;
        assign rsp_hit           = pop & (head_id == IdW'(gi));
        assign host_gnt_o[gi]    = accept & (win_idx == IdW'(gi));
        assign host_rvalid_o[gi] = rsp_hit;
        assign host_err_o[gi]    = rsp_hit & dev_err_i;
        assign host_rdata_o[gi]  = rsp_hit ? dev_rdata_i : '0;
    end

    bus_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .pop_i   (pop),
        .wdata_i (win_idx),
        .rdata_o (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && (Mode == ArbRoundRobin)) begin
            rr_ptr_d = (win_idx == IdW'(NrHosts - 1)) ? '0 : win_idx + IdW'(1);
        end
        unexp_d = unexp_q | (dev_rvalid_i & fifo_empty);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            unexp_q  <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            unexp_q  <= unexp_d;
        end
    end

    assign unexp_rsp_o = unexp_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with shared stimulus and
// checks both against a queue-based model of the arbitration rules.
module tb_bus_rr_arbiter;

    localparam int NH = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;
    localparam int CW = $clog2(MO + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req   [NH];
    logic [AW-1:0] addr  [NH];
    logic          we    [NH];
    logic [3:0]    be    [NH];
    logic [DW-1:0] wdata [NH];
    logic          dev_gnt, dev_rvalid, dev_err;
    logic [DW-1:0] dev_rdata;

    logic          dev_req   [2];
    logic [AW-1:0] dev_addr  [2];
    logic          dev_we    [2];
    logic [3:0]    dev_be    [2];
    logic [DW-1:0] dev_wdata [2];
    logic [CW-1:0] outst     [2];
    logic          unexp     [2];

    logic          gnt_a [NH], rv_a [NH], er_a [NH];
    logic [DW-1:0] rd_a  [NH];
    logic          gnt_b [NH], rv_b [NH], er_b [NH];
    logic [DW-1:0] rd_b  [NH];

    bus_rr_arbiter #(
        .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW),
        .MaxOutstanding(MO), .RoundRobin(1'b1)
    ) u_rr (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(req), .host_addr_i(addr), .host_we_i(we), .host_be_i(be), .host_wdata_i(wdata),
        .host_gnt_o(gnt_a), .host_rvalid_o(rv_a), .host_err_o(er_a), .host_rdata_o(rd_a),
        .dev_req_o(dev_req[0]), .dev_addr_o(dev_addr[0]), .dev_we_o(dev_we[0]),
        .dev_be_o(dev_be[0]), .dev_wdata_o(dev_wdata[0]),
        .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_err_i(dev_err), .dev_rdata_i(dev_rdata),
        .outstanding_o(outst[0]), .unexp_rsp_o(unexp[0])
    );

    bus_rr_arbiter #(
        .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW),
        .MaxOutstanding(MO), .RoundRobin(1'b0)
    ) u_fixed (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(req), .host_addr_i(addr), .host_we_i(we), .host_be_i(be), .host_wdata_i(wdata),
        .host_gnt_o(gnt_b), .host_rvalid_o(rv_b), .host_err_o(er_b), .host_rdata_o(rd_b),
        .dev_req_o(dev_req[1]), .dev_addr_o(dev_addr[1]), .dev_we_o(dev_we[1]),
        .dev_be_o(dev_be[1]), .dev_wdata_o(dev_wdata[1]),
        .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid), .dev_err_i(dev_err), .dev_rdata_i(dev_rdata),
        .outstanding_o(outst[1]), .unexp_rsp_o(unexp[1])
    );

    // Reference model: per instance, a queue of accepted host IDs in accept order.
    int idq [2][$];
    int rr_m [2];
    bit unexp_m [2];
    int win_m [2];
    bit acc_m [2];

    int checks = 0;
    int errors = 0;

    int            gidx_a, gidx_b, rvidx_a;
    logic          snap_req_a, snap_unexp_a, snap_rv_any_a;
    logic [CW-1:0] snap_out_a;
    logic          snap_rv_a [NH], snap_er_a [NH];
    logic [DW-1:0] snap_rd_a [NH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        for (int m = 0; m < 2; m++) begin
            int  w;
            int  start;
            bit  full, ereq, ervalid;
            logic g, rv, er;
            logic [DW-1:0] rd;
            w     = -1;
            start = (m == 0) ? rr_m[m] : 0;
            for (int k = 0; k < NH; k++) begin
                if (w < 0 && req[(start + k) % NH]) w = (start + k) % NH;
            end
            full     = (idq[m].size() == MO);
            ereq     = (w >= 0) && !full && !rst;
            acc_m[m] = ereq && dev_gnt;
            win_m[m] = w;
            chk($sformatf("dev_req[%0d]", m), 64'(dev_req[m]), 64'(ereq));
            chk($sformatf("dev_addr[%0d]", m), 64'(dev_addr[m]), ereq ? 64'(addr[w]) : 64'd0);
            chk($sformatf("dev_we[%0d]", m), 64'(dev_we[m]), ereq ? 64'(we[w]) : 64'd0);
            chk($sformatf("dev_be[%0d]", m), 64'(dev_be[m]), ereq ? 64'(be[w]) : 64'd0);
            chk($sformatf("dev_wdata[%0d]", m), 64'(dev_wdata[m]), ereq ? 64'(wdata[w]) : 64'd0);
            for (int h = 0; h < NH; h++) begin
                g  = (m == 0) ? gnt_a[h] : gnt_b[h];
                rv = (m == 0) ? rv_a[h]  : rv_b[h];
                er = (m == 0) ? er_a[h]  : er_b[h];
                rd = (m == 0) ? rd_a[h]  : rd_b[h];
                ervalid = dev_rvalid && (idq[m].size() > 0) && (idq[m][0] == h);
                chk($sformatf("gnt[%0d][%0d]", m, h), 64'(g), 64'(acc_m[m] && (w == h)));
                chk($sformatf("rvalid[%0d][%0d]", m, h), 64'(rv), 64'(ervalid));
                chk($sformatf("rdata[%0d][%0d]", m, h), 64'(rd), ervalid ? 64'(dev_rdata) : 64'd0);
                chk($sformatf("err[%0d][%0d]", m, h), 64'(er), 64'(ervalid && dev_err));
            end
            chk($sformatf("outstanding[%0d]", m), 64'(outst[m]), 64'(idq[m].size()));
            chk($sformatf("unexp[%0d]", m), 64'(unexp[m]), 64'(unexp_m[m]));
        end
    endtask

    task automatic update_model();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                idq[m].delete();
                rr_m[m]    = 0;
                unexp_m[m] = 1'b0;
            end else begin
                if (dev_rvalid) begin
                    if (idq[m].size() > 0) void'(idq[m].pop_front());
                    else unexp_m[m] = 1'b1;
                end
                if (acc_m[m]) begin
                    idq[m].push_back(win_m[m]);
                    if (m == 0) rr_m[m] = (win_m[m] + 1) % NH;
                end
            end
        end
    endtask

    // Inputs are set while clk is low; outputs are sampled 1ns later.
    task automatic cycle();
        #1;
        check_model();
        gidx_a  = -1;
        gidx_b  = -1;
        rvidx_a = -1;
        for (int h = NH - 1; h >= 0; h--) begin
            if (gnt_a[h]) gidx_a = h;
            if (gnt_b[h]) gidx_b = h;
            if (rv_a[h])  rvidx_a = h;
        end
        snap_req_a    = dev_req[0];
        snap_out_a    = outst[0];
        snap_unexp_a  = unexp[0];
        snap_rv_any_a = rv_a[0] | rv_a[1] | rv_a[2];
        snap_rv_a     = rv_a;
        snap_er_a     = er_a;
        snap_rd_a     = rd_a;
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic set_hosts(input logic [NH-1:0] v);
        for (int h = 0; h < NH; h++) begin
            req[h]   = v[h];
            addr[h]  = $urandom;
            we[h]    = 1'($urandom);
            be[h]    = 4'($urandom);
            wdata[h] = $urandom;
        end
    endtask

    task automatic set_dev(input logic g, input logic rv, input logic [DW-1:0] d, input logic e);
        dev_gnt    = g;
        dev_rvalid = rv;
        dev_rdata  = d;
        dev_err    = e;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_hosts('0);
        set_dev(1'b0, 1'b0, '0, 1'b0);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_hosts('1);
        set_dev(1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);

        // Reset forces the request side quiet even with every host requesting.
        cycle();
        chk("rst_dev_req", 64'(snap_req_a), 64'd0);
        chk("rst_no_gnt", 64'(gidx_a), 64'(-1));
        cycle();
        chk("rst_outstanding", 64'(snap_out_a), 64'd0);
        chk("rst_unexp", 64'(snap_unexp_a), 64'd0);

        // All hosts request, device grants every cycle and answers one cycle later.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_hosts('1);
            set_dev(1'b1, i > 0, $urandom, 1'b0);
            cycle();
            chk("rr_grant_order", 64'(gidx_a), 64'(i % 3));
            chk("fixed_grant_host0", 64'(gidx_b), 64'd0);
            if (i > 0) chk("rr_rsp_host", 64'(rvidx_a), 64'((i - 1) % 3));
        end
        set_hosts('0);
        set_dev(1'b0, 1'b1, $urandom, 1'b0);
        cycle();

        // Tracker fills at two and a same-cycle pop does not reopen it.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_hosts(3'b010);
            set_dev(1'b1, 1'b0, '0, 1'b0);
            cycle();
        end
        chk("full_outstanding", 64'(snap_out_a), 64'd2);
        chk("full_blocks_req", 64'(snap_req_a), 64'd0);
        set_hosts(3'b010);
        set_dev(1'b1, 1'b1, $urandom, 1'b0);
        cycle();
        chk("full_pop_same_cycle", 64'(snap_req_a), 64'd0);
        set_hosts(3'b010);
        set_dev(1'b1, 1'b0, '0, 1'b0);
        cycle();
        chk("reenable_after_pop", 64'(snap_req_a), 64'd1);
        chk("reenable_outstanding", 64'(snap_out_a), 64'd1);

        // Accept host 2 then host 0; responses come back in that order.
        do_reset();
        set_hosts(3'b100);
        set_dev(1'b1, 1'b0, '0, 1'b0);
        cycle();
        set_hosts(3'b001);
        cycle();
        set_hosts('0);
        set_dev(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
        cycle();
        chk("rsp1_host2_valid", 64'(snap_rv_a[2]), 64'd1);
        chk("rsp1_host2_rdata", 64'(snap_rd_a[2]), 64'hA5A5A5A5);
        chk("rsp1_host2_err", 64'(snap_er_a[2]), 64'd0);
        set_dev(1'b0, 1'b1, 32'h5A5A5A5A, 1'b1);
        cycle();
        chk("rsp2_host0_valid", 64'(snap_rv_a[0]), 64'd1);
        chk("rsp2_host0_rdata", 64'(snap_rd_a[0]), 64'h5A5A5A5A);
        chk("rsp2_host0_err", 64'(snap_er_a[0]), 64'd1);

        // A response with nothing outstanding is dropped and latched as unexpected.
        do_reset();
        set_dev(1'b0, 1'b1, $urandom, 1'b0);
        cycle();
        chk("unexp_no_rvalid", 64'(snap_rv_any_a), 64'd0);
        set_dev(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("unexp_sticky", 64'(snap_unexp_a), 64'd1);
        end

        // Reset with two outstanding discards them; a late response is unexpected.
        do_reset();
        set_hosts(3'b001);
        set_dev(1'b1, 1'b0, '0, 1'b0);
        cycle();
        set_hosts(3'b010);
        cycle();
        rst = 1'b1;
        set_hosts('1);
        cycle();
        chk("rst_blocks_req", 64'(snap_req_a), 64'd0);
        rst = 1'b0;
        set_hosts('0);
        set_dev(1'b0, 1'b1, $urandom, 1'b0);
        cycle();
        chk("late_rsp_dropped", 64'(snap_rv_any_a), 64'd0);
        chk("post_rst_outstanding", 64'(snap_out_a), 64'd0);
        set_hosts('1);
        set_dev(1'b1, 1'b0, '0, 1'b0);
        cycle();
        chk("post_rst_unexp", 64'(snap_unexp_a), 64'd1);
        chk("post_rst_rr_start", 64'(gidx_a), 64'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_hosts(NH'($urandom));
            set_dev(($urandom % 4) != 0, 1'($urandom), $urandom, 1'($urandom));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
